// File: rtl/zbus_buffer_arbiter.sv
// zbus_buffer_arbiter
// Arbitrates the shared Zorro address/data buffers between host slave
// accesses to the SCSI region and NCR bus-master tenures. Each tenure runs
// address phase -> data phase -> turnaround, and every buffer enable,
// direction strobe, grant and bus request is registered from the next state.
//
// Ports:
//   CLK, RESET        board clock, synchronous active-high reset
//   slv_req/read/done slave access request, direction (1=host read), NCR ack
//   mst_req/read/done NCR bus request, direction (1=NCR reads Zorro), end
//   zbg               Zorro bus grant (active high)
//   zbr               Zorro bus request
//   slv_gnt, mst_gnt  current buffer owner
//   ABOE_n, DBOE_n    address / data buffer enables (active low)
//   D2Z_n, Z2D_n      data direction strobes (active low)
//   slv_timeout       one-cycle pulse when a slave data phase times out
//   state             encoded FSM state (debug)
module zbus_buffer_arbiter #(
  parameter int TURN_CYCLES = 1,
  parameter int TIMEOUT     = 255
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       slv_req,
  input  logic       slv_read,
  input  logic       slv_done,
  input  logic       mst_req,
  input  logic       mst_read,
  input  logic       mst_done,
  input  logic       zbg,
  output logic       zbr,
  output logic       slv_gnt,
  output logic       mst_gnt,
  output logic       ABOE_n,
  output logic       DBOE_n,
  output logic       D2Z_n,
  output logic       Z2D_n,
  output logic       slv_timeout,
  output logic [2:0] state
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CMAX  = CW'((TIMEOUT == 0) ? 1 : TIMEOUT);
  localparam logic [2:0]    TLOAD = 3'(TURN_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    M_REQ  = 3'd3,
    M_OWN  = 3'd4,
    TURN   = 3'd5
  } state_t;

  state_t        st;
  state_t        nxt;
  logic          last_mst;   // 1 when the master held the buffers last
  logic          s_read;
  logic          m_read;
  logic [CW-1:0] tmo_cnt;
  logic [2:0]    turn_cnt;
  logic          tmo_hit;
  logic          tmo_pulse;
  logic          m_dir;

  assign state = st;

  // The master direction is only latched on the M_REQ->M_OWN edge, so the
  // strobes for that same edge must come straight from the input.
  assign m_dir = (st == M_REQ) ? mst_read : m_read;

  always_comb begin
    nxt       = st;
    tmo_pulse = 1'b0;
    // tmo_cnt holds the number of completed S_DATA cycles
    tmo_hit   = (TIMEOUT > 0) && (st == S_DATA) && (int'(tmo_cnt) >= TIMEOUT - 1);
    case (st)
      IDLE: begin
        if (slv_req && (!mst_req || last_mst))
          nxt = S_ADDR;
        else if (mst_req)
          nxt = M_REQ;
      end
      S_ADDR: nxt = slv_req ? S_DATA : TURN;
      S_DATA: begin
        if (slv_done || !slv_req || tmo_hit)
          nxt = TURN;
        // an acknowledge in the timeout cycle is a normal completion
        tmo_pulse = tmo_hit && !slv_done;
      end
      M_REQ: begin
        // buffers were never enabled, so an abort skips the turnaround
        if (!mst_req)
          nxt = IDLE;
        else if (zbg)
          nxt = M_OWN;
      end
      M_OWN: begin
        if (mst_done || !mst_req || !zbg)
          nxt = TURN;
      end
      TURN: begin
        if (turn_cnt == 3'd0)
          nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Registered state, counters and outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      st          <= IDLE;
      last_mst    <= 1'b1;
      tmo_cnt     <= '0;
      turn_cnt    <= '0;
      zbr         <= 1'b0;
      slv_gnt     <= 1'b0;
      mst_gnt     <= 1'b0;
      ABOE_n      <= 1'b1;
      DBOE_n      <= 1'b1;
      D2Z_n       <= 1'b1;
      Z2D_n       <= 1'b1;
      slv_timeout <= 1'b0;
    end else begin
      st <= nxt;
      if (nxt == S_ADDR)
        last_mst <= 1'b0;
      else if (st == M_REQ && nxt == M_OWN)
        last_mst <= 1'b1;

      if (nxt == S_ADDR)
        tmo_cnt <= '0;
      else if (st == S_DATA && nxt == S_DATA && tmo_cnt != CMAX)
        tmo_cnt <= tmo_cnt + CW'(1);

      if (nxt == TURN && st != TURN)
        turn_cnt <= TLOAD;
      else if (st == TURN && turn_cnt != 3'd0)
        turn_cnt <= turn_cnt - 3'd1;

      zbr         <= (nxt == M_REQ) || (nxt == M_OWN);
      slv_gnt     <= (nxt == S_ADDR) || (nxt == S_DATA);
      mst_gnt     <= (nxt == M_OWN);
      ABOE_n      <= !((nxt == S_ADDR) || (nxt == S_DATA) || (nxt == M_OWN));
      DBOE_n      <= !((nxt == S_DATA) || (nxt == M_OWN));
      D2Z_n       <= !(((nxt == S_DATA) && s_read) || ((nxt == M_OWN) && !m_dir));
      Z2D_n       <= !(((nxt == S_DATA) && !s_read) || ((nxt == M_OWN) && m_dir));
      slv_timeout <= tmo_pulse;
    end
  end

  // Direction latches: only meaningful while their owner holds the buffers
  always_ff @(posedge CLK) begin
    if (st == IDLE && nxt == S_ADDR)
      s_read <= slv_read;
    if (st == M_REQ && nxt == M_OWN)
      m_read <= mst_read;
  end

endmodule

// File: tb/tb_zbus_buffer_arbiter.sv
// Bench for zbus_buffer_arbiter: two instances (short turnaround with a
// 4-cycle timeout, long turnaround with timeout disabled) share one input
// vector and are each compared against a tenure-level reference model.
module tb_zbus_buffer_arbiter;

  localparam int T0 = 1, TO0 = 4;
  localparam int T1 = 3, TO1 = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // {RESET, slv_req, slv_read, slv_done, mst_req, mst_read, mst_done, zbg}
  logic [7:0] iv = 8'h80;

  logic [1:0] zbr, slv_gnt, mst_gnt, ABOE_n, DBOE_n, D2Z_n, Z2D_n, slv_timeout;
  logic [2:0] state0, state1;

  zbus_buffer_arbiter #(.TURN_CYCLES(T0), .TIMEOUT(TO0)) dut0 (
    .CLK(clk), .RESET(iv[7]), .slv_req(iv[6]), .slv_read(iv[5]), .slv_done(iv[4]),
    .mst_req(iv[3]), .mst_read(iv[2]), .mst_done(iv[1]), .zbg(iv[0]),
    .zbr(zbr[0]), .slv_gnt(slv_gnt[0]), .mst_gnt(mst_gnt[0]), .ABOE_n(ABOE_n[0]),
    .DBOE_n(DBOE_n[0]), .D2Z_n(D2Z_n[0]), .Z2D_n(Z2D_n[0]),
    .slv_timeout(slv_timeout[0]), .state(state0));

  zbus_buffer_arbiter #(.TURN_CYCLES(T1), .TIMEOUT(TO1)) dut1 (
    .CLK(clk), .RESET(iv[7]), .slv_req(iv[6]), .slv_read(iv[5]), .slv_done(iv[4]),
    .mst_req(iv[3]), .mst_read(iv[2]), .mst_done(iv[1]), .zbg(iv[0]),
    .zbr(zbr[1]), .slv_gnt(slv_gnt[1]), .mst_gnt(mst_gnt[1]), .ABOE_n(ABOE_n[1]),
    .DBOE_n(DBOE_n[1]), .D2Z_n(D2Z_n[1]), .Z2D_n(Z2D_n[1]),
    .slv_timeout(slv_timeout[1]), .state(state1));

  // Reference model: which phase of which tenure we are in
  localparam int P_IDLE = 0, P_SADDR = 1, P_SDATA = 2, P_MREQ = 3, P_MOWN = 4, P_TURN = 5;

  typedef struct {
    int ph;
    int dcnt;        // data cycles spent so far in this slave tenure
    int tleft;       // turnaround cycles remaining
    bit last_slave;  // slave owned the buffers most recently
    bit sread;
    bit mread;
    bit tpulse;
  } mdl_t;

  typedef struct {
    logic [7:0] in;
    logic [7:0] exp;   // {zbr,slv_gnt,mst_gnt,ABOE_n,DBOE_n,D2Z_n,Z2D_n,slv_timeout}
  } vec_t;

  mdl_t m0, m1;
  vec_t tbl[$];
  int n_checks = 0;
  int n_pass = 0;
  logic [1:0] pdboe = 2'b11, pd2z = 2'b11, pz2d = 2'b11;
  bit sreq_r = 0, mreq_r = 0;

  function automatic mdl_t step(mdl_t m, logic [7:0] in, int turn, int tmo);
    mdl_t n = m;
    n.tpulse = 1'b0;
    if (in[7]) begin
      n.ph = P_IDLE; n.last_slave = 1'b0; n.dcnt = 0; n.tleft = 0;
      return n;
    end
    case (m.ph)
      P_IDLE: begin
        if (in[6] && (!in[3] || !m.last_slave)) begin
          n.ph = P_SADDR; n.sread = in[5]; n.last_slave = 1'b1;
        end else if (in[3]) n.ph = P_MREQ;
      end
      P_SADDR: begin
        if (in[6]) begin n.ph = P_SDATA; n.dcnt = 1; end
        else begin n.ph = P_TURN; n.tleft = turn; end
      end
      P_SDATA: begin
        if (in[4]) begin n.ph = P_TURN; n.tleft = turn; end
        else if (tmo > 0 && m.dcnt >= tmo) begin n.ph = P_TURN; n.tleft = turn; n.tpulse = 1'b1; end
        else if (!in[6]) begin n.ph = P_TURN; n.tleft = turn; end
        else n.dcnt = m.dcnt + 1;
      end
      P_MREQ: begin
        if (!in[3]) n.ph = P_IDLE;
        else if (in[0]) begin n.ph = P_MOWN; n.mread = in[2]; n.last_slave = 1'b0; end
      end
      P_MOWN: begin
        if (in[1] || !in[3] || !in[0]) begin n.ph = P_TURN; n.tleft = turn; end
      end
      default: begin
        n.tleft = m.tleft - 1;
        if (n.tleft <= 0) n.ph = P_IDLE;
      end
    endcase
    return n;
  endfunction

  function automatic logic [7:0] pins(mdl_t m);
    logic sd, mo;
    sd = (m.ph == P_SDATA);
    mo = (m.ph == P_MOWN);
    return {m.ph == P_MREQ || mo,
            m.ph == P_SADDR || sd,
            mo,
            !(m.ph == P_SADDR || sd || mo),
            !(sd || mo),
            !((sd && m.sread) || (mo && !m.mread)),
            !((sd && !m.sread) || (mo && m.mread)),
            m.tpulse};
  endfunction

  function automatic logic [7:0] obs(int d);
    return {zbr[d], slv_gnt[d], mst_gnt[d], ABOE_n[d], DBOE_n[d], D2Z_n[d], Z2D_n[d], slv_timeout[d]};
  endfunction

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
  endtask

  task automatic inv(string name, bit ok);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: invariant broken, outputs %b at %0t", name, {obs(1), obs(0)}, $time);
  endtask

  // One clock: sample after the edge, advance both models, compare
  task automatic cycle();
    @(posedge clk);
    #1;
    m0 = step(m0, iv, T0, TO0);
    m1 = step(m1, iv, T1, TO1);
    check("model0", obs(0), pins(m0));
    check("model1", obs(1), pins(m1));
    for (int d = 0; d < 2; d++) begin
      inv($sformatf("dir_excl%0d", d), !(D2Z_n[d] === 1'b0 && Z2D_n[d] === 1'b0));
      inv($sformatf("gnt_excl%0d", d), !(slv_gnt[d] === 1'b1 && mst_gnt[d] === 1'b1));
      inv($sformatf("dboe_dir%0d", d), DBOE_n[d] !== 1'b0 || ((D2Z_n[d] ^ Z2D_n[d]) === 1'b1));
      inv($sformatf("dir_stable%0d", d), !(pdboe[d] === 1'b0 && DBOE_n[d] === 1'b0) ||
          (D2Z_n[d] === pd2z[d] && Z2D_n[d] === pz2d[d]));
      pdboe[d] = DBOE_n[d];
      pd2z[d]  = D2Z_n[d];
      pz2d[d]  = Z2D_n[d];
    end
  endtask

  function automatic vec_t v(logic [7:0] i, logic [7:0] e);
    vec_t r;
    r.in = i;
    r.exp = e;
    return r;
  endfunction

  initial begin
    int gap;
    // reset
    tbl.push_back(v(8'b1_000_0000, 8'h1E));
    // slave read, ack on the fourth data cycle
    tbl.push_back(v(8'b0_110_0000, 8'h4E));
    repeat (4) tbl.push_back(v(8'b0_110_0000, 8'h42));
    tbl.push_back(v(8'b0_111_0000, 8'h1E));
    tbl.push_back(v(8'b0_000_0000, 8'h1E));
    // slave write, no ack: four data cycles then timeout pulse in TURN
    tbl.push_back(v(8'b0_100_0000, 8'h4E));
    repeat (4) tbl.push_back(v(8'b0_100_0000, 8'h44));
    tbl.push_back(v(8'b0_100_0000, 8'h1F));
    tbl.push_back(v(8'b0_000_0000, 8'h1E));
    tbl.push_back(v(8'b0_000_0000, 8'h1E));
    // master read, grant after 5 request cycles, then grant revoked
    repeat (5) tbl.push_back(v(8'b0_000_1100, 8'h9E));
    tbl.push_back(v(8'b0_000_1101, 8'hA4));
    tbl.push_back(v(8'b0_000_1101, 8'hA4));
    tbl.push_back(v(8'b0_000_1100, 8'h1E));
    tbl.push_back(v(8'b0_000_0000, 8'h1E));
    // master aborts before grant: straight back to IDLE, slave served next cycle
    tbl.push_back(v(8'b0_000_1000, 8'h9E));
    tbl.push_back(v(8'b0_000_0000, 8'h1E));
    tbl.push_back(v(8'b0_110_0000, 8'h4E));
    tbl.push_back(v(8'b0_110_0000, 8'h42));
    tbl.push_back(v(8'b0_000_0000, 8'h1E));
    tbl.push_back(v(8'b0_000_0000, 8'h1E));
    // reset in the middle of a slave write, then a normal write
    tbl.push_back(v(8'b0_100_0000, 8'h4E));
    tbl.push_back(v(8'b0_100_0000, 8'h44));
    tbl.push_back(v(8'b1_100_0000, 8'h1E));
    tbl.push_back(v(8'b0_100_0000, 8'h4E));
    tbl.push_back(v(8'b0_100_0000, 8'h44));
    tbl.push_back(v(8'b0_101_0000, 8'h1E));
    tbl.push_back(v(8'b0_000_0000, 8'h1E));
    // both request from reset: slave, TURN, master, TURN, slave
    tbl.push_back(v(8'b1_000_0000, 8'h1E));
    tbl.push_back(v(8'b0_110_1001, 8'h4E));
    tbl.push_back(v(8'b0_110_1001, 8'h42));
    tbl.push_back(v(8'b0_111_1001, 8'h1E));
    tbl.push_back(v(8'b0_110_1001, 8'h1E));
    tbl.push_back(v(8'b0_110_1001, 8'h9E));
    tbl.push_back(v(8'b0_110_1001, 8'hA2));
    tbl.push_back(v(8'b0_110_1011, 8'h1E));
    tbl.push_back(v(8'b0_110_1001, 8'h1E));
    tbl.push_back(v(8'b0_110_1001, 8'h4E));
    tbl.push_back(v(8'b1_000_0000, 8'h1E));

    for (int k = 0; k < tbl.size(); k++) begin
      @(negedge clk);
      iv = tbl[k].in;
      cycle();
      check($sformatf("vec%0d", k), obs(0), tbl[k].exp);
    end

    // long slave write: instance 1 never times out, then a 3-cycle turnaround
    @(negedge clk); iv = 8'b1_000_0000; cycle();
    @(negedge clk); iv = 8'b0_100_0000; cycle();
    repeat (300) begin @(negedge clk); cycle(); end
    check("no_timeout1", {5'b0, slv_gnt[1], DBOE_n[1], slv_timeout[1]}, 8'b0000_0100);
    @(negedge clk); iv = 8'b0_101_0000; cycle();
    iv = 8'b0_100_0000;
    gap = 0;
    while (slv_gnt[1] !== 1'b1 && gap < 20) begin
      @(negedge clk);
      cycle();
      gap++;
    end
    check("turn_gap1", 8'(gap), 8'(T1 + 1));

    // randomized traffic against the models
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      sreq_r = sreq_r ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 3) == 0);
      mreq_r = mreq_r ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 3) == 0);
      iv = {1'($urandom_range(0, 99) == 0), sreq_r, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 5) == 0), mreq_r, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) != 0)};
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
